// File: rtl/imem_loader.sv
// imem_loader: program loader and instruction memory for the sequential core.
//
// A byte stream arrives over a valid/ready handshake. Bytes are packed
// little-endian into 32-bit words and written into a word-addressed memory.
// The core's fetch port reads that memory combinationally. cpu_run stays low
// until a complete program has been loaded.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   ld_start     - pulse: begin a new load, discard the previous program
//   ld_valid     - ld_byte is valid
//   ld_byte      - program byte, least-significant byte of each word first
//   ld_last      - marks the final byte of the program
//   ld_ready     - loader accepts a byte this cycle (registered)
//   fetch_pc     - byte address from the core's PC
//   fetch_inst   - instruction at fetch_pc, combinational
//   cpu_run      - program loaded, core may advance (registered)
//   load_err     - last load failed, sticky until next ld_start (registered)
//   words_loaded - words written by the current or last load (registered)

module imem_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [63:0]   fetch_pc,
    output logic [31:0]   fetch_inst,
    output logic          cpu_run,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    localparam logic [AW:0] LastIdx = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [AW:0]      ptr_q, ptr_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [23:0]      asm_q, asm_d;
    logic [DEPTH-1:0] vbit_q, vbit_d;
    logic             ld_ready_q, ld_ready_d;
    logic             cpu_run_q, cpu_run_d;
    logic             load_err_q, load_err_d;
    logic [AW:0]      words_loaded_q, words_loaded_d;

    // Memory contents are deliberately not reset; vbit alone marks validity.
    logic [31:0]      mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [31:0]      mem_wdata;

    logic             transfer;

    // ld_ready_q mirrors "state is LOAD", so this is the handshake.
    assign transfer = ld_valid && ld_ready_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        bidx_d         = bidx_q;
        asm_d          = asm_q;
        vbit_d         = vbit_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        mem_we         = 1'b0;
        mem_waddr      = ptr_q[AW-1:0];
        mem_wdata      = {ld_byte, asm_q};

        if (ld_start) begin
            // Start (or restart) a load from any state; a same-cycle
            // transfer is ignored.
            state_d        = StLoad;
            ptr_d          = '0;
            bidx_d         = 2'd0;
            vbit_d         = '0;
            load_err_d     = 1'b0;
            words_loaded_d = '0;
        end else if (transfer) begin
            if (bidx_q != 2'd3) begin
                case (bidx_q)
                    2'd0:    asm_d[7:0]   = ld_byte;
                    2'd1:    asm_d[15:8]  = ld_byte;
                    default: asm_d[23:16] = ld_byte;
                endcase
                bidx_d = bidx_q + 2'd1;
                if (ld_last) begin
                    // Program ends mid-word: drop the partial word.
                    state_d    = StIdle;
                    bidx_d     = 2'd0;
                    load_err_d = 1'b1;
                end
            end else begin
                mem_we                 = 1'b1;
                vbit_d[ptr_q[AW-1:0]]  = 1'b1;
                ptr_d                  = ptr_q + 1'b1;
                bidx_d                 = 2'd0;
                words_loaded_d         = ptr_q + 1'b1;
                if (ld_last) begin
                    state_d = StRun;
                end else if (ptr_q == LastIdx) begin
                    // Memory full but the stream has not ended.
                    state_d    = StIdle;
                    load_err_d = 1'b1;
                end
            end
        end

        ld_ready_d = (state_d == StLoad);
        cpu_run_d  = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            bidx_q         <= 2'd0;
            asm_q          <= '0;
            vbit_q         <= '0;
            ld_ready_q     <= 1'b0;
            cpu_run_q      <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            bidx_q         <= bidx_d;
            asm_q          <= asm_d;
            vbit_q         <= vbit_d;
            ld_ready_q     <= ld_ready_d;
            cpu_run_q      <= cpu_run_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Fetch: aligned, in range, and loaded; anything else reads as NOP.
    logic [AW-1:0] fetch_idx;
    logic          fetch_ok;

    assign fetch_idx = fetch_pc[AW+1:2];

    always_comb begin
        fetch_ok   = (fetch_pc[1:0] == 2'b00) && (fetch_pc[63:AW+2] == '0) &&
                     vbit_q[fetch_idx];
        fetch_inst = fetch_ok ? mem_q[fetch_idx] : NOP;
    end

    assign ld_ready     = ld_ready_q;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.

module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0020_83B3;
    localparam logic [31:0] W1  = 32'h0041_8433;

    logic        clk;
    logic        rst_n;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        cpu_run;
    logic        load_err;
    logic [6:0]  words_loaded;

    int n_checks;
    int n_fail;

    logic [7:0] prog [8];

    imem_loader #(
        .DEPTH (64),
        .AW    (6),
        .NOP   (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .fetch_pc     (fetch_pc),
        .fetch_inst   (fetch_inst),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [63:0] pc,
                               input logic [31:0] exp);
        fetch_pc = pc;
        #1;
        check(tag, {32'd0, fetch_inst}, {32'd0, exp});
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prog[0] = 8'hB3; prog[1] = 8'h83; prog[2] = 8'h20; prog[3] = 8'h00;
        prog[4] = 8'h33; prog[5] = 8'h84; prog[6] = 8'h41; prog[7] = 8'h00;

        rst_n    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        ld_last  = 1'b0;
        fetch_pc = 64'd0;
        #12;

        // Reset state
        check("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
        check("rst_cpu_run", {63'd0, cpu_run}, 64'd0);
        check("rst_load_err", {63'd0, load_err}, 64'd0);
        check("rst_words", {57'd0, words_loaded}, 64'd0);
        check_fetch("rst_fetch0", 64'd0, NOP);
        rst_n = 1'b1;
        tick();

        // Load 1: byte offered during the ld_start cycle must not be taken
        ld_valid = 1'b1;
        ld_byte  = 8'hFF;
        pulse_start();
        ld_valid = 1'b0;
        check("l1_ready_after_start", {63'd0, ld_ready}, 64'd1);
        for (int i = 0; i < 8; i++) send(prog[i], (i == 7));
        check("l1_cpu_run", {63'd0, cpu_run}, 64'd1);
        check("l1_ready_low", {63'd0, ld_ready}, 64'd0);
        check("l1_words", {57'd0, words_loaded}, 64'd2);
        check("l1_err", {63'd0, load_err}, 64'd0);
        check_fetch("l1_pc0", 64'd0, W0);
        check_fetch("l1_pc4", 64'd4, W1);
        check_fetch("l1_pc8", 64'd8, NOP);
        check_fetch("l1_pc2_misaligned", 64'd2, NOP);

        // ld_start from RUN clears the program
        pulse_start();
        check("rerun_cpu_run", {63'd0, cpu_run}, 64'd0);
        check("rerun_ready", {63'd0, ld_ready}, 64'd1);
        check("rerun_words", {57'd0, words_loaded}, 64'd0);
        check_fetch("rerun_pc0", 64'd0, NOP);
        check_fetch("rerun_pc4", 64'd4, NOP);

        // Load 2: valid gap of 3 cycles between bytes 5 and 6
        for (int i = 0; i < 5; i++) send(prog[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_ready", {63'd0, ld_ready}, 64'd1);
        end
        for (int i = 5; i < 8; i++) send(prog[i], (i == 7));
        check("l2_cpu_run", {63'd0, cpu_run}, 64'd1);
        check("l2_words", {57'd0, words_loaded}, 64'd2);
        check_fetch("l2_pc0", 64'd0, W0);
        check_fetch("l2_pc4", 64'd4, W1);

        // Load 3: ld_last on 6th byte -> partial word dropped, error
        pulse_start();
        for (int i = 0; i < 6; i++) send(prog[i], (i == 5));
        check("short_err", {63'd0, load_err}, 64'd1);
        check("short_cpu_run", {63'd0, cpu_run}, 64'd0);
        check("short_ready", {63'd0, ld_ready}, 64'd0);
        check("short_words", {57'd0, words_loaded}, 64'd1);
        check_fetch("short_pc0", 64'd0, W0);
        check_fetch("short_pc4", 64'd4, NOP);

        // Load 4: 256 bytes without ld_last -> overflow error
        pulse_start();
        check("ovf_err_cleared", {63'd0, load_err}, 64'd0);
        for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
        check("ovf_words_63", {57'd0, words_loaded}, 64'd63);
        check("ovf_ready_before", {63'd0, ld_ready}, 64'd1);
        send(8'hFF, 1'b0);
        check("ovf_err", {63'd0, load_err}, 64'd1);
        check("ovf_words_64", {57'd0, words_loaded}, 64'd64);
        check("ovf_ready_after", {63'd0, ld_ready}, 64'd0);
        check("ovf_cpu_run", {63'd0, cpu_run}, 64'd0);
        check_fetch("ovf_pc0", 64'd0, 32'h0302_0100);
        check_fetch("ovf_pc252", 64'd252, 32'hFFFE_FDFC);
        check_fetch("ovf_pc256_range", 64'd256, NOP);
        check_fetch("ovf_pc_high", 64'h1_0000_0000, NOP);
        check_fetch("ovf_pc2_misaligned", 64'd2, NOP);

        // Restart in LOAD: same-cycle transfer ignored, partial bytes discarded
        pulse_start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        ld_valid = 1'b1;
        ld_byte  = 8'hCC;
        pulse_start();
        ld_valid = 1'b0;
        check("restart_ready", {63'd0, ld_ready}, 64'd1);
        check("restart_words", {57'd0, words_loaded}, 64'd0);
        for (int i = 0; i < 8; i++) send(prog[i], (i == 7));
        check("restart_cpu_run", {63'd0, cpu_run}, 64'd1);
        check_fetch("restart_pc0", 64'd0, W0);
        check_fetch("restart_pc4", 64'd4, W1);

        // Async reset after 5 bytes of a load
        pulse_start();
        for (int i = 0; i < 5; i++) send(prog[i], 1'b0);
        check("pre_rst_words", {57'd0, words_loaded}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, ld_ready}, 64'd0);
        check("arst_words", {57'd0, words_loaded}, 64'd0);
        check("arst_cpu_run", {63'd0, cpu_run}, 64'd0);
        check_fetch("arst_pc0", 64'd0, NOP);
        #20;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, ld_ready}, 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
